// File: rtl/peripheral_gpio_apb4_arbiter.sv
// Round-robin APB4 master sharing one GPIO APB4 slave between NREQ req/ack requesters; optional APB_TIMEOUT_EN access timeout.
// Latency: req rise in IDLE -> PSEL +1 cycle -> ack +3 cycles with a zero-wait slave; back-to-back transfers have no idle cycle.
// Backpressure: PREADY low stretches ACCESS; requesters hold req_i until their one-cycle ack_o pulse.
module peripheral_gpio_apb4_arbiter #(
    parameter int NREQ           = 2,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NREQ-1:0]                  req_i,
    input  logic [NREQ-1:0]                  req_write_i,
    input  logic [NREQ*APB_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NREQ*APB_DATA_WIDTH-1:0]   req_wdata_i,
    output logic [NREQ-1:0]                  gnt_o,
    output logic [NREQ-1:0]                  ack_o,
    output logic [APB_DATA_WIDTH-1:0]        rdata_o,
    output logic                             err_o,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [APB_ADDR_WIDTH-1:0]        PADDR,
    output logic [APB_DATA_WIDTH-1:0]        PWDATA,
    input  logic [APB_DATA_WIDTH-1:0]        PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [IDXW-1:0]           r_rr;
    logic [IDXW-1:0]           r_owner;
    logic [NREQ-1:0]           r_gnt;
    logic [NREQ-1:0]           r_ack;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;

    logic [IDXW-1:0]           w_owner_inc;
    logic [IDXW-1:0]           w_ptr;
    logic [NREQ-1:0]           w_req_m;
    logic [IDXW:0]             w_sum;
    logic [IDXW-1:0]           w_idx;
    logic                      w_pick_vld;
    logic [IDXW-1:0]           w_pick_idx;
    logic                      w_done;
    logic                      w_tmo;
    logic                      w_end;
    logic                      w_load;

    assign w_owner_inc = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_done      = (r_state == S_ACCESS) && PREADY;
    assign w_end       = w_done || w_tmo;

`ifdef APB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    assign w_tmo = (r_state == S_ACCESS) && !PREADY &&
                   (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !w_end) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // A requester still shows req_i during its ack cycle, so it is masked
    // there; in the finishing ACCESS cycle the current owner is masked too.
    always_comb begin
        w_ptr      = r_rr;
        w_req_m    = req_i & ~r_ack;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_sum      = '0;
        w_idx      = '0;
        if (r_state == S_ACCESS) begin
            w_ptr            = w_owner_inc;
            w_req_m[r_owner] = 1'b0;
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, w_ptr} + (IDXW + 1)'(k);
            if (w_sum >= (IDXW + 1)'(NREQ)) begin
                w_sum = w_sum - (IDXW + 1)'(NREQ);
            end
            w_idx = w_sum[IDXW-1:0];
            if (w_req_m[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_SETUP;
                    w_load      = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                end else if (w_done) begin
                    if (w_pick_vld) begin
                        w_state_nxt = S_SETUP;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_rr     <= '0;
            r_owner  <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else begin
            r_ack   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            if (w_end) begin
                r_ack   <= r_gnt;
                r_err   <= w_tmo ? 1'b1 : PSLVERR;
                r_rdata <= (r_pwrite || w_tmo) ? '0 : PRDATA;
                r_rr    <= w_owner_inc;
            end
            if (w_load) begin
                r_gnt    <= NREQ'(1) << w_pick_idx;
                r_owner  <= w_pick_idx;
                r_pwrite <= req_write_i[w_pick_idx];
                r_paddr  <= req_addr_i[w_pick_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                r_pwdata <= req_wdata_i[w_pick_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end else if (w_end) begin
                r_gnt <= '0;
            end
        end
    end

    assign PSEL    = (r_state != S_IDLE);
    assign PENABLE = (r_state == S_ACCESS);
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign gnt_o   = r_gnt;
    assign ack_o   = r_ack;
    assign rdata_o = r_rdata;
    assign err_o   = r_err;

endmodule

// File: tb/tb_peripheral_gpio_apb4_arbiter.sv
// Directed vector table plus multi-cycle sequences for the APB4 arbiter, and a random fairness run on a 4-requester instance.
module tb_peripheral_gpio_apb4_arbiter;

    localparam logic [31:0] RD = 32'hA5A5_0001;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [1:0]  gnt, ack;
    logic [31:0] rdata;
    logic        err, psel, pen, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;

    logic [3:0]   req4, wr4, gnt4, ack4;
    logic [31:0]  addr4;
    logic [127:0] wdata4;
    logic [31:0]  prdata4, rdata4, pwdata4;
    logic         pready4, pslverr4, err4, psel4, pen4, pwrite4;
    logic [7:0]   paddr4;

    int total = 0;
    int bad   = 0;

    peripheral_gpio_apb4_arbiter #(
        .NREQ(2), .APB_ADDR_WIDTH(8), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .HCLK(clk), .HRESETn(rstn),
        .req_i(req), .req_write_i(wr), .req_addr_i(addr), .req_wdata_i(wdata),
        .gnt_o(gnt), .ack_o(ack), .rdata_o(rdata), .err_o(err),
        .PSEL(psel), .PENABLE(pen), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    peripheral_gpio_apb4_arbiter #(
        .NREQ(4), .APB_ADDR_WIDTH(8), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) u_dut4 (
        .HCLK(clk), .HRESETn(rstn),
        .req_i(req4), .req_write_i(wr4), .req_addr_i(addr4), .req_wdata_i(wdata4),
        .gnt_o(gnt4), .ack_o(ack4), .rdata_o(rdata4), .err_o(err4),
        .PSEL(psel4), .PENABLE(pen4), .PWRITE(pwrite4), .PADDR(paddr4), .PWDATA(pwdata4),
        .PRDATA(prdata4), .PREADY(pready4), .PSLVERR(pslverr4)
    );

    typedef struct packed {
        logic        rstn;
        logic [1:0]  req;
        logic        psel;
        logic        pen;
        logic        pwrite;
        logic [1:0]  gnt;
        logic [1:0]  ack;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  paddr;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t v(input logic r, input logic [1:0] q, input logic ps, input logic pe,
                               input logic pw, input logic [1:0] g, input logic [1:0] a,
                               input logic [31:0] d, input logic e, input logic [7:0] pa);
        vec_t t;
        t = {r, q, ps, pe, pw, g, a, d, e, pa};
        return t;
    endfunction

    task automatic check(input string name, input logic ok, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [47:0] act;
        logic [47:0] exp_o;
        logic        ok;
        int          cyc;
        logic        got;
        logic [3:0]  pend;
        int          waitc[4];
        int          maxw, acks, accepted, onehot_bad, stray;

        // single read (req0 @0x04), a reset, then 0/1 contention with rr=0
        vt[0]  = v(1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 8'h00);
        vt[1]  = v(1, 2'b01, 1, 0, 0, 2'b01, 2'b00, 32'h0, 0, 8'h04);
        vt[2]  = v(1, 2'b01, 1, 1, 0, 2'b01, 2'b00, 32'h0, 0, 8'h04);
        vt[3]  = v(1, 2'b01, 0, 0, 0, 2'b00, 2'b01, RD,    0, 8'h04);
        vt[4]  = v(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 8'h04);
        vt[5]  = v(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 8'h00);
        vt[6]  = v(1, 2'b11, 1, 0, 0, 2'b01, 2'b00, 32'h0, 0, 8'h04);
        vt[7]  = v(1, 2'b11, 1, 1, 0, 2'b01, 2'b00, 32'h0, 0, 8'h04);
        vt[8]  = v(1, 2'b11, 1, 0, 1, 2'b10, 2'b01, RD,    0, 8'h10);
        vt[9]  = v(1, 2'b11, 1, 1, 1, 2'b10, 2'b00, 32'h0, 0, 8'h10);
        vt[10] = v(1, 2'b11, 1, 0, 0, 2'b01, 2'b10, 32'h0, 0, 8'h04);
        vt[11] = v(1, 2'b11, 1, 1, 0, 2'b01, 2'b00, 32'h0, 0, 8'h04);
        vt[12] = v(1, 2'b10, 1, 0, 1, 2'b10, 2'b01, RD,    0, 8'h10);
        vt[13] = v(1, 2'b10, 1, 1, 1, 2'b10, 2'b00, 32'h0, 0, 8'h10);
        vt[14] = v(1, 2'b10, 0, 0, 1, 2'b00, 2'b10, 32'h0, 0, 8'h10);
        vt[15] = v(1, 2'b00, 0, 0, 1, 2'b00, 2'b00, 32'h0, 0, 8'h10);

        rstn = 1'b0; req = 2'b00; wr = 2'b10;
        addr = {8'h10, 8'h04}; wdata = {32'hDEAD_BEEF, 32'h0};
        prdata = RD; pready = 1'b1; pslverr = 1'b0;
        req4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0;
        prdata4 = '0; pready4 = 1'b0; pslverr4 = 1'b0;

        repeat (2) @(negedge clk);
        act = {psel, pen, pwrite, gnt, ack, rdata, err, paddr, 5'b0};
        check("reset_state", act == 48'h0, 64'(act), 64'h0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rstn = vt[i].rstn;
            req  = vt[i].req;
            act   = {psel, pen, pwrite, gnt, ack, rdata, err, paddr, 5'b0};
            exp_o = {vt[i].psel, vt[i].pen, vt[i].pwrite, vt[i].gnt, vt[i].ack,
                     vt[i].rdata, vt[i].err, vt[i].paddr, 5'b0};
            total++;
            if (act !== exp_o) begin
                bad++;
                $display("FAIL vec%0d: got psel=%b pen=%b pwr=%b gnt=%b ack=%b rdata=%h err=%b paddr=%h want psel=%b pen=%b pwr=%b gnt=%b ack=%b rdata=%h err=%b paddr=%h",
                         i, psel, pen, pwrite, gnt, ack, rdata, err, paddr,
                         vt[i].psel, vt[i].pen, vt[i].pwrite, vt[i].gnt, vt[i].ack,
                         vt[i].rdata, vt[i].err, vt[i].paddr);
            end
        end

        // write with 5 wait states then PSLVERR: address/data stable for 7 PSEL cycles
        @(negedge clk);
        req = 2'b10; pready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ok = psel && (pen == (i != 0)) && pwrite && paddr == 8'h10 &&
                 pwdata == 32'hDEAD_BEEF && gnt == 2'b10 && ack == 2'b00;
            check($sformatf("wait_stable_%0d", i), ok,
                  {22'b0, psel, pen, pwrite, gnt, ack, paddr, pwdata},
                  {22'b0, 1'b1, (i != 0), 1'b1, 2'b10, 2'b00, 8'h10, 32'hDEAD_BEEF});
            if (i == 6) begin
                pready = 1'b1; pslverr = 1'b1;
            end
        end
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0; req = 2'b00;
        check("wait_err_ack", ack == 2'b10 && err && rdata == 32'h0 && !psel,
              {27'b0, psel, ack, err, rdata}, {27'b0, 1'b0, 2'b10, 1'b1, 32'h0});

        // requester 0 read moves the rr pointer to 1
        @(negedge clk);
        req = 2'b01; pready = 1'b1;
        repeat (3) @(negedge clk);
        check("rr_setup_read", ack == 2'b01 && rdata == RD && !err,
              {29'b0, ack, err, rdata}, {29'b0, 2'b01, 1'b0, RD});
        req = 2'b00;

        // reset during a wait state of requester 1
        @(negedge clk);
        req = 2'b10; pready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_access", psel && pen && gnt == 2'b10,
              {60'b0, psel, pen, gnt}, {60'b0, 1'b1, 1'b1, 2'b10});
        rstn = 1'b0;
        @(negedge clk);
        check("rst_abort", !psel && !pen && gnt == 2'b00 && ack == 2'b00,
              {58'b0, psel, pen, gnt, ack}, 64'h0);
        rstn = 1'b1; req = 2'b11; pready = 1'b1;
        @(negedge clk);
        check("rst_restart_rr0", psel && !pen && gnt == 2'b01 && ack == 2'b00 && paddr == 8'h04,
              {50'b0, psel, pen, gnt, ack, paddr}, {50'b0, 1'b1, 1'b0, 2'b01, 2'b00, 8'h04});
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("req_drop_still_ack", ack == 2'b01 && rdata == RD && !psel,
              {29'b0, psel, ack, rdata}, {29'b0, 1'b0, 2'b01, RD});
        @(negedge clk);
        check("idle_outputs_zero", ack == 2'b00 && rdata == 32'h0 && !err,
              {29'b0, ack, err, rdata}, 64'h0);

        // slave never ready
        req = 2'b01; pready = 1'b0;
        cyc = 0; got = 1'b0;
`ifdef APB_TIMEOUT_EN
        while (cyc < 100 && !got) begin
            @(negedge clk);
            cyc++;
            if (ack != 2'b00) got = 1'b1;
        end
        check("timeout_ack", got && cyc == 18 && ack == 2'b01 && err && rdata == 32'h0 && !psel,
              {cyc, 27'b0, ack, err, psel, got}, {32'd18, 27'b0, 2'b01, 1'b1, 1'b0, 1'b1});
        req = 2'b00;
        @(negedge clk);
`else
        ok = 1'b1;
        @(negedge clk);
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (!(psel && pen && ack == 2'b00)) ok = 1'b0;
        end
        check("no_timeout_wait", ok, {61'b0, psel, pen, ok}, {61'b0, 1'b1, 1'b1, 1'b1});
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; req = 2'b00;
        @(negedge clk);
`endif

        // fairness on the 4-requester instance
        pend = '0; maxw = 0; acks = 0; accepted = 0; onehot_bad = 0; stray = 0;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int c = 0; c < 3200; c++) begin
            @(negedge clk);
            if ((gnt4 & (gnt4 - 4'd1)) != 4'd0) onehot_bad++;
            if ($countones(ack4) > 1) onehot_bad++;
            for (int i = 0; i < 4; i++) begin
                if (ack4[i]) begin
                    acks++;
                    if (!pend[i]) stray++;
                    pend[i] = 1'b0;
                    req4[i] = 1'b0;
                    for (int j = 0; j < 4; j++) begin
                        if (j != i && pend[j]) begin
                            waitc[j]++;
                            if (waitc[j] > maxw) maxw = waitc[j];
                        end
                    end
                end
            end
            pready4  = 1'($urandom_range(0, 1));
            pslverr4 = 1'($urandom_range(0, 1));
            prdata4  = $urandom;
            if (c < 3000) begin
                for (int i = 0; i < 4; i++) begin
                    if (!pend[i] && $urandom_range(0, 3) == 0) begin
                        pend[i]         = 1'b1;
                        waitc[i]        = 0;
                        req4[i]         = 1'b1;
                        wr4[i]          = 1'($urandom_range(0, 1));
                        addr4[i*8 +: 8] = 8'($urandom);
                        accepted++;
                    end
                end
            end
        end
        check("fair_onehot", onehot_bad == 0, 64'(onehot_bad), 64'h0);
        check("fair_max_wait", maxw <= 3, 64'(maxw), 64'd3);
        check("fair_no_stray_ack", stray == 0, 64'(stray), 64'h0);
        check("fair_ack_count", acks == accepted && pend == 4'b0 && accepted > 100,
              {28'b0, pend, 32'(acks)}, {32'b0, 32'(accepted)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
